// File: rtl/inert_cal_seq.sv
// Purpose : calibration sequencer ahead of the gyro heading integrator; settles, pulses strt_cal,
//           waits for cal_done with timeout/retry, gates "moving". Optional INERT_AUTO_RECAL_EN.
// Latency : start@k -> strt_cal@k+1+SETTLE_CYC; cal_done@j -> cal_ok@j+1; no backpressure (pulse I/O).
module inert_cal_seq #(
  parameter int SETTLE_CYC  = 4096,
  parameter int TIMEOUT_CYC = 1048576,
  parameter int MAX_RETRY   = 2,
  parameter int STILL_CYC   = 65536
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       moving_req,
  input  logic       cal_done,
  output logic       strt_cal,
  output logic       moving,
  output logic       cal_ok,
  output logic       cal_err,
  output logic       busy,
  output logic [1:0] retry_cnt,
  output logic [7:0] cal_cnt
);

  localparam int MAX_AB  = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
  localparam int MAX_CYC = (MAX_AB > STILL_CYC) ? MAX_AB : STILL_CYC;
  localparam int TW      = $clog2(MAX_CYC) + 1;

  localparam logic [TW-1:0] SETTLE_LAST  = TW'(SETTLE_CYC - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYC - 1);
`ifdef INERT_AUTO_RECAL_EN
  localparam logic [TW-1:0] STILL_LAST   = TW'(STILL_CYC - 1);
`endif
  localparam logic [1:0]    RETRY_MAX    = 2'(MAX_RETRY);
  localparam logic [TW-1:0] TIMER_ONE    = TW'(1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETTLE   = 3'd1,
    CAL_REQ  = 3'd2,
    CAL_WAIT = 3'd3,
    RUN      = 3'd4,
    ERR      = 3'd5
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [TW-1:0] timer;
  logic [1:0]    retry_q;
  logic [7:0]    cal_cnt_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode; cal_done outranks the timeout and any start seen in CAL_WAIT
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (start) state_nxt = SETTLE;
      SETTLE:   if (timer == SETTLE_LAST) state_nxt = CAL_REQ;
      CAL_REQ:  state_nxt = CAL_WAIT;
      CAL_WAIT: begin
        if (cal_done)
          state_nxt = RUN;
        else if (timer == TIMEOUT_LAST)
          state_nxt = (retry_q < RETRY_MAX) ? CAL_REQ : ERR;
      end
      RUN: begin
        if (start) state_nxt = SETTLE;
`ifdef INERT_AUTO_RECAL_EN
        // Long stillness is a free recalibration window; same path as start
        if (!moving_req && (timer == STILL_LAST)) state_nxt = SETTLE;
`endif
      end
      ERR:      if (start) state_nxt = SETTLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Shared timer: settle/timeout count, or still count in RUN; zeroed on every state change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer <= '0;
    end else if (state_nxt != state) begin
      timer <= '0;
    end else begin
      case (state)
        SETTLE, CAL_WAIT: timer <= timer + TIMER_ONE;
`ifdef INERT_AUTO_RECAL_EN
        RUN:              timer <= moving_req ? '0 : timer + TIMER_ONE;
`endif
        default:          timer <= '0;
      endcase
    end
  end

  // Retry count: cleared on each new attempt, bumped per timeout re-issue, held in RUN/ERR
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retry_q <= '0;
    end else if ((state_nxt == SETTLE) && (state != SETTLE)) begin
      retry_q <= '0;
    end else if ((state == CAL_WAIT) && (state_nxt == CAL_REQ)) begin
      retry_q <= retry_q + 2'd1;
    end
  end

  // Saturating count of successful calibrations
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cal_cnt_q <= '0;
    end else if ((state == CAL_WAIT) && cal_done && (cal_cnt_q != 8'hFF)) begin
      cal_cnt_q <= cal_cnt_q + 8'd1;
    end
  end

  // Output decode from registered state; moving_req is the only direct input->output path
  always_comb begin
    strt_cal = 1'b0;
    busy     = 1'b0;
    cal_ok   = 1'b0;
    cal_err  = 1'b0;
    moving   = 1'b0;
    case (state)
      SETTLE:   busy = 1'b1;
      CAL_REQ:  begin busy = 1'b1; strt_cal = 1'b1; end
      CAL_WAIT: busy = 1'b1;
      RUN:      begin cal_ok = 1'b1; moving = moving_req; end
      ERR:      cal_err = 1'b1;
      default:  ;
    endcase
  end

  assign retry_cnt = retry_q;
  assign cal_cnt   = cal_cnt_q;

endmodule
